// File: rtl/io_input_conditioner_if.sv
// io_input_conditioner_if: raw pins and clear requests in, clean values and change flags out.
//   master: the conditioner (takes raw pins/clears, drives clean/sticky/strobe)
//   slave : the IO memory side (drives raw pins/clears, reads clean/sticky/strobe)
interface io_input_conditioner_if #(
    parameter int NUM_SW   = 5,
    parameter int NUM_GPIO = 36
);
    logic [NUM_SW-1:0]          sw_raw;
    logic [NUM_GPIO-1:0]        gpio_raw;
    logic [NUM_SW+NUM_GPIO-1:0] clr_sticky;
    logic [NUM_SW-1:0]          sw_clean;
    logic [NUM_GPIO-1:0]        gpio_clean;
    logic [NUM_SW+NUM_GPIO-1:0] chg_sticky;
    logic                       chg_strobe;
    modport master (
        input  sw_raw, gpio_raw, clr_sticky,
        output sw_clean, gpio_clean, chg_sticky, chg_strobe
    );
    modport slave (
        output sw_raw, gpio_raw, clr_sticky,
        input  sw_clean, gpio_clean, chg_sticky, chg_strobe
    );
endinterface

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: 2-flop synchronizer plus per-bit debounce, sticky change flags and change strobe.
//   clk, rst (async, active-high); bus: io_input_conditioner_if.master
//   bit i of the internal vector: switches at [NUM_SW-1:0], gpio j at NUM_SW+j
module io_input_conditioner #(
    parameter int NUM_SW          = 5,
    parameter int NUM_GPIO        = 36,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic clk,
    input logic rst,
    io_input_conditioner_if.master bus
);
    localparam int N  = NUM_SW + NUM_GPIO;
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  in_raw, sync1_q, sync2_q, clean_q, clean_d, sticky_q, sticky_d, upd;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic          strobe_q, strobe_d;

    assign in_raw = {bus.gpio_raw, bus.sw_raw};

    // Any return of sync2 to the clean value restarts the count: no accumulation across bounces.
    always_comb begin
        upd = '0;
        for (int i = 0; i < N; i++) begin
            upd[i]   = (sync2_q[i] != clean_q[i]) && (cnt_q[i] == CNT_MAX);
            cnt_d[i] = (sync2_q[i] == clean_q[i] || upd[i]) ? '0 : cnt_q[i] + CW'(1);
        end
        clean_d  = clean_q ^ upd;
        sticky_d = upd | (sticky_q & ~bus.clr_sticky);
        strobe_d = |upd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            clean_q  <= '0;
            sticky_q <= '0;
            strobe_q <= 1'b0;
            cnt_q    <= '{default: '0};
        end else begin
            sync1_q  <= in_raw;
            sync2_q  <= sync1_q;
            clean_q  <= clean_d;
            sticky_q <= sticky_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.sw_clean   = clean_q[NUM_SW-1:0];
    assign bus.gpio_clean = clean_q[N-1:NUM_SW];
    assign bus.chg_sticky = sticky_q;
    assign bus.chg_strobe = strobe_q;
endmodule
